// File: rtl/vc_allocation.sv
// Per-input-port virtual-channel allocator. It latches one routing result, picks a free
// VC on the requested output port round-robin, and keeps the busy-VC table for every port.
module vc_allocation #(
    parameter int no_outport              = 6,
    parameter int no_vc                   = 13,
    parameter int floorplusone_log2_no_vc = 4
) (
    input  logic                                          clk,
    input  logic                                          rs,
    input  logic                                          rc_valid,
    input  logic [no_outport-1:0]                         outport_vec,
    input  logic [no_vc-1:0]                              allow_vcs,
    input  logic                                          va_ack,
    input  logic                                          rel_valid,
    input  logic [no_outport-1:0]                         rel_outport,
    input  logic [no_vc-1:0]                              rel_vc,
    output logic                                          va_valid,
    output logic [no_outport-1:0]                         va_outport,
    output logic [no_vc-1:0]                              va_vc,
    output logic                                          va_idle,
    output logic                                          req_err,
    output logic [no_outport*floorplusone_log2_no_vc-1:0] busies
);
    localparam int cw  = floorplusone_log2_no_vc;
    localparam int sw  = cw + 1;
    localparam int pw  = (no_outport > 1) ? $clog2(no_outport) : 1;
    localparam int pcw = $clog2(no_outport + 1);
    localparam logic [cw-1:0] last_vc = cw'(no_vc - 1);

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_alloc = 2'd1,
        st_grant = 2'd2
    } state_t;

    function automatic logic [cw-1:0] popcount_vc(input logic [no_vc-1:0] v);
        logic [cw-1:0] c;
        c = {cw{1'b0}};
        for (int i = 0; i < no_vc; i++) begin
            c = c + cw'(v[i]);
        end
        return c;
    endfunction

    function automatic logic onehot_vc(input logic [no_vc-1:0] v);
        return popcount_vc(v) == cw'(1'b1);
    endfunction

    function automatic logic onehot_port(input logic [no_outport-1:0] v);
        logic [pcw-1:0] c;
        c = {pcw{1'b0}};
        for (int i = 0; i < no_outport; i++) begin
            c = c + pcw'(v[i]);
        end
        return c == pcw'(1'b1);
    endfunction

    function automatic logic [pw-1:0] port_index(input logic [no_outport-1:0] v);
        logic [pw-1:0] idx;
        idx = {pw{1'b0}};
        for (int i = 0; i < no_outport; i++) begin
            idx = v[i] ? pw'(i) : idx;
        end
        return idx;
    endfunction

    state_t                  state_r, state_s;
    logic [pw-1:0]           port_idx_r, port_idx_s;
    logic [no_outport-1:0]   port_vec_r, port_vec_s;
    logic [no_vc-1:0]        allow_r, allow_s;
    logic [no_vc-1:0]        table_r [no_outport];
    logic [no_vc-1:0]        table_s [no_outport];
    logic [cw-1:0]           ptr_r   [no_outport];
    logic [cw-1:0]           ptr_s   [no_outport];
    logic                    va_valid_r, va_valid_s;
    logic [no_outport-1:0]   va_outport_r, va_outport_s;
    logic [no_vc-1:0]        va_vc_r, va_vc_s;
    logic                    va_idle_r;
    logic                    req_err_r, req_err_s;
    logic [no_outport*cw-1:0] busies_r;

    logic [no_vc-1:0]        cand_s;
    logic                    hit_s;
    logic [cw-1:0]           hit_idx_s;
    logic [sw-1:0]           probe_s;

    // Round-robin search over the allowed, currently free VCs of the latched port
    always_comb begin
        cand_s    = allow_r & ~table_r[port_idx_r];
        hit_s     = 1'b0;
        hit_idx_s = {cw{1'b0}};
        probe_s   = {sw{1'b0}};
        for (int i = 0; i < no_vc; i++) begin
            probe_s   = {1'b0, ptr_r[port_idx_r]} + sw'(i);
            probe_s   = (probe_s >= sw'(no_vc)) ? (probe_s - sw'(no_vc)) : probe_s;
            hit_idx_s = (!hit_s && cand_s[probe_s[cw-1:0]]) ? probe_s[cw-1:0] : hit_idx_s;
            hit_s     = hit_s | cand_s[probe_s[cw-1:0]];
        end
    end

    // FSM next state, request latch, table/pointer updates and grant outputs
    always_comb begin
        state_s      = state_r;
        port_idx_s   = port_idx_r;
        port_vec_s   = port_vec_r;
        allow_s      = allow_r;
        table_s      = table_r;
        ptr_s        = ptr_r;
        va_valid_s   = va_valid_r;
        va_outport_s = va_outport_r;
        va_vc_s      = va_vc_r;
        req_err_s    = req_err_r;

        // release is applied first so a same-cycle grant on another entry is kept as well
        if (rel_valid) begin
            if (onehot_port(rel_outport) && onehot_vc(rel_vc)) begin
                table_s[port_index(rel_outport)] = table_r[port_index(rel_outport)] & ~rel_vc;
            end else begin
                req_err_s = 1'b1;
            end
        end else begin
            req_err_s = req_err_s;
        end

        case (state_r)
            st_idle: begin
                if (rc_valid) begin
                    if (onehot_port(outport_vec) && (allow_vcs != {no_vc{1'b0}})) begin
                        port_vec_s = outport_vec;
                        port_idx_s = port_index(outport_vec);
                        allow_s    = allow_vcs;
                        state_s    = st_alloc;
                    end else begin
                        req_err_s = 1'b1;
                    end
                end else begin
                    state_s = st_idle;
                end
            end
            st_alloc: begin
                req_err_s = req_err_s | rc_valid;
                if (hit_s) begin
                    table_s[port_idx_r] = table_s[port_idx_r] | ({{(no_vc-1){1'b0}}, 1'b1} << hit_idx_s);
                    ptr_s[port_idx_r]   = (hit_idx_s == last_vc) ? {cw{1'b0}} : (hit_idx_s + cw'(1'b1));
                    va_valid_s          = 1'b1;
                    va_outport_s        = port_vec_r;
                    va_vc_s             = {{(no_vc-1){1'b0}}, 1'b1} << hit_idx_s;
                    state_s             = st_grant;
                end else begin
                    state_s = st_alloc;
                end
            end
            st_grant: begin
                req_err_s = req_err_s | rc_valid;
                if (va_ack) begin
                    va_valid_s   = 1'b0;
                    va_outport_s = {no_outport{1'b0}};
                    va_vc_s      = {no_vc{1'b0}};
                    state_s      = st_idle;
                end else begin
                    state_s = st_grant;
                end
            end
            default: begin
                state_s = st_idle;
            end
        endcase
    end

    // State, latch, table, pointers and registered outputs; busies lag the table by one cycle
    always_ff @(posedge clk) begin
        if (rs) begin
            state_r      <= st_idle;
            port_idx_r   <= {pw{1'b0}};
            port_vec_r   <= {no_outport{1'b0}};
            allow_r      <= {no_vc{1'b0}};
            va_valid_r   <= 1'b0;
            va_outport_r <= {no_outport{1'b0}};
            va_vc_r      <= {no_vc{1'b0}};
            va_idle_r    <= 1'b1;
            req_err_r    <= 1'b0;
            busies_r     <= {(no_outport*cw){1'b0}};
            for (int i = 0; i < no_outport; i++) begin
                table_r[i] <= {no_vc{1'b0}};
                ptr_r[i]   <= {cw{1'b0}};
            end
        end else begin
            state_r      <= state_s;
            port_idx_r   <= port_idx_s;
            port_vec_r   <= port_vec_s;
            allow_r      <= allow_s;
            va_valid_r   <= va_valid_s;
            va_outport_r <= va_outport_s;
            va_vc_r      <= va_vc_s;
            va_idle_r    <= (state_s == st_idle);
            req_err_r    <= req_err_s;
            for (int i = 0; i < no_outport; i++) begin
                table_r[i]            <= table_s[i];
                ptr_r[i]              <= ptr_s[i];
                busies_r[i*cw +: cw]  <= popcount_vc(table_r[i]);
            end
        end
    end

    assign va_valid   = va_valid_r;
    assign va_outport = va_outport_r;
    assign va_vc      = va_vc_r;
    assign va_idle    = va_idle_r;
    assign req_err    = req_err_r;
    assign busies     = busies_r;

endmodule

// File: tb/tb_vc_allocation.sv
// Directed, table-driven bench for vc_allocation: each vector drives one clock edge and
// compares every output against hand-computed values just after that edge.
module tb_vc_allocation;

    typedef struct {
        logic        rs;
        logic        rc_valid;
        logic [5:0]  outport_vec;
        logic [12:0] allow_vcs;
        logic        va_ack;
        logic        rel_valid;
        logic [5:0]  rel_outport;
        logic [12:0] rel_vc;
        logic        e_valid;
        logic [5:0]  e_outport;
        logic [12:0] e_vc;
        logic        e_idle;
        logic        e_err;
        logic [23:0] e_busies;
    } vec_t;

    logic        clk;
    logic        rs, rc_valid, va_ack, rel_valid;
    logic [5:0]  outport_vec, rel_outport;
    logic [12:0] allow_vcs, rel_vc;
    logic        va_valid, va_idle, req_err;
    logic [5:0]  va_outport;
    logic [12:0] va_vc;
    logic [23:0] busies;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl [20];

    vc_allocation #(.no_outport(6), .no_vc(13), .floorplusone_log2_no_vc(4)) dut (
        .clk(clk), .rs(rs), .rc_valid(rc_valid), .outport_vec(outport_vec),
        .allow_vcs(allow_vcs), .va_ack(va_ack), .rel_valid(rel_valid),
        .rel_outport(rel_outport), .rel_vc(rel_vc), .va_valid(va_valid),
        .va_outport(va_outport), .va_vc(va_vc), .va_idle(va_idle),
        .req_err(req_err), .busies(busies)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] bus(input int p, input int n);
        logic [23:0] b;
        b = 24'd0;
        b[p*4 +: 4] = 4'(n);
        return b;
    endfunction

    function automatic vec_t mk(input logic r, input logic rc, input logic [5:0] op,
                                input logic [12:0] al, input logic ack, input logic rv,
                                input logic [5:0] rp, input logic [12:0] rvc,
                                input logic ev, input logic [5:0] eop, input logic [12:0] evc,
                                input logic ei, input logic ee, input logic [23:0] eb);
        vec_t v;
        v.rs = r; v.rc_valid = rc; v.outport_vec = op; v.allow_vcs = al; v.va_ack = ack;
        v.rel_valid = rv; v.rel_outport = rp; v.rel_vc = rvc;
        v.e_valid = ev; v.e_outport = eop; v.e_vc = evc; v.e_idle = ei; v.e_err = ee;
        v.e_busies = eb;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [45:0] got, want;
        rs = v.rs; rc_valid = v.rc_valid; outport_vec = v.outport_vec; allow_vcs = v.allow_vcs;
        va_ack = v.va_ack; rel_valid = v.rel_valid; rel_outport = v.rel_outport; rel_vc = v.rel_vc;
        @(posedge clk);
        #1;
        got  = {va_valid, va_outport, va_vc, va_idle, req_err, busies};
        want = {v.e_valid, v.e_outport, v.e_vc, v.e_idle, v.e_err, v.e_busies};
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got valid=%b port=%b vc=%h idle=%b err=%b busies=%h, want valid=%b port=%b vc=%h idle=%b err=%b busies=%h",
                     name, va_valid, va_outport, va_vc, va_idle, req_err, busies,
                     v.e_valid, v.e_outport, v.e_vc, v.e_idle, v.e_err, v.e_busies);
        end
        @(negedge clk);
    endtask

    localparam logic [5:0]  p0 = 6'b000001, p1 = 6'b000010, p2 = 6'b000100;
    localparam logic [5:0]  p3 = 6'b001000, p5 = 6'b100000, z6 = 6'b000000;
    localparam logic [12:0] all = 13'h1FFF, z13 = 13'h0000;

    initial begin
        // reset, single grant on port 2, malformed requests, dropped request in GRANT
        tbl[0]  = mk(1, 0, z6, z13, 0, 0, z6, z13,           0, z6, z13, 1, 0, 24'd0);
        tbl[1]  = mk(0, 1, p2, all, 0, 0, z6, z13,           0, z6, z13, 0, 0, 24'd0);
        tbl[2]  = mk(0, 0, z6, z13, 0, 0, z6, z13,           1, p2, 13'h0001, 0, 0, 24'd0);
        tbl[3]  = mk(0, 0, z6, z13, 0, 0, z6, z13,           1, p2, 13'h0001, 0, 0, bus(2, 1));
        tbl[4]  = mk(0, 0, z6, z13, 1, 0, z6, z13,           0, z6, z13, 1, 0, bus(2, 1));
        tbl[5]  = mk(0, 0, z6, z13, 0, 1, p2, 13'h0001,      0, z6, z13, 1, 0, bus(2, 1));
        tbl[6]  = mk(0, 0, z6, z13, 0, 0, z6, z13,           0, z6, z13, 1, 0, 24'd0);
        tbl[7]  = mk(0, 1, 6'b000011, all, 0, 0, z6, z13,    0, z6, z13, 1, 1, 24'd0);
        tbl[8]  = mk(1, 0, z6, z13, 0, 0, z6, z13,           0, z6, z13, 1, 0, 24'd0);
        tbl[9]  = mk(0, 1, p1, all, 0, 0, z6, z13,           0, z6, z13, 0, 0, 24'd0);
        tbl[10] = mk(0, 0, z6, z13, 0, 0, z6, z13,           1, p1, 13'h0001, 0, 0, 24'd0);
        tbl[11] = mk(0, 1, p2, all, 0, 0, z6, z13,           1, p1, 13'h0001, 0, 1, bus(1, 1));
        tbl[12] = mk(0, 0, z6, z13, 0, 0, z6, z13,           1, p1, 13'h0001, 0, 1, bus(1, 1));
        tbl[13] = mk(0, 0, z6, z13, 1, 0, z6, z13,           0, z6, z13, 1, 1, bus(1, 1));
        tbl[14] = mk(0, 0, z6, z13, 0, 1, p1, 13'h0001,      0, z6, z13, 1, 1, bus(1, 1));
        tbl[15] = mk(1, 0, z6, z13, 0, 0, z6, z13,           0, z6, z13, 1, 0, 24'd0);
        tbl[16] = mk(0, 0, z6, z13, 0, 1, p0, 13'h0003,      0, z6, z13, 1, 1, 24'd0);
        tbl[17] = mk(1, 0, z6, z13, 0, 0, z6, z13,           0, z6, z13, 1, 0, 24'd0);
        tbl[18] = mk(0, 1, p0, z13, 0, 0, z6, z13,           0, z6, z13, 1, 1, 24'd0);
        tbl[19] = mk(1, 0, z6, z13, 0, 0, z6, z13,           0, z6, z13, 1, 0, 24'd0);

        rs = 1'b1; rc_valid = 1'b0; outport_vec = z6; allow_vcs = z13;
        va_ack = 1'b0; rel_valid = 1'b0; rel_outport = z6; rel_vc = z13;

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // 13 back-to-back requests to port 0 step VC0..VC12
        for (int k = 0; k < 13; k++) begin
            apply(mk(0, 1, p0, all, 0, 0, z6, z13, 0, z6, z13, 0, 0, bus(0, k)), $sformatf("rr_req%0d", k));
            apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 1, p0, 13'h0001 << k, 0, 0, bus(0, k)), $sformatf("rr_grant%0d", k));
            apply(mk(0, 0, z6, z13, 1, 0, z6, z13, 0, z6, z13, 1, 0, bus(0, k + 1)), $sformatf("rr_ack%0d", k));
        end
        // port full: the 14th request waits in ALLOC until VC5 is released
        apply(mk(0, 1, p0, all, 0, 0, z6, z13, 0, z6, z13, 0, 0, bus(0, 13)), "full_req");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 0, z6, z13, 0, 0, bus(0, 13)), "full_wait1");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 0, z6, z13, 0, 0, bus(0, 13)), "full_wait2");
        apply(mk(0, 0, z6, z13, 0, 1, p0, 13'h0020, 0, z6, z13, 0, 0, bus(0, 13)), "full_rel");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 1, p0, 13'h0020, 0, 0, bus(0, 12)), "full_grant5");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 1, p0, 13'h0020, 0, 0, bus(0, 13)), "full_hold");
        apply(mk(0, 0, z6, z13, 1, 0, z6, z13, 0, z6, z13, 1, 0, bus(0, 13)), "full_ack");
        apply(mk(1, 0, z6, z13, 0, 0, z6, z13, 0, z6, z13, 1, 0, 24'd0), "rst2");

        // port 3: make VC4 busy with the pointer at 4, then allow_vcs=0x0F0
        apply(mk(0, 1, p3, 13'h0010, 0, 0, z6, z13, 0, z6, z13, 0, 0, 24'd0), "p3_req4");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 1, p3, 13'h0010, 0, 0, 24'd0), "p3_grant4");
        apply(mk(0, 0, z6, z13, 1, 0, z6, z13, 0, z6, z13, 1, 0, bus(3, 1)), "p3_ack4");
        apply(mk(0, 1, p3, 13'h0008, 0, 0, z6, z13, 0, z6, z13, 0, 0, bus(3, 1)), "p3_req3");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 1, p3, 13'h0008, 0, 0, bus(3, 1)), "p3_grant3_wrap");
        apply(mk(0, 0, z6, z13, 1, 0, z6, z13, 0, z6, z13, 1, 0, bus(3, 2)), "p3_ack3");
        apply(mk(0, 0, z6, z13, 0, 1, p3, 13'h0008, 0, z6, z13, 1, 0, bus(3, 2)), "p3_rel3");
        apply(mk(0, 1, p3, 13'h00F0, 0, 0, z6, z13, 0, z6, z13, 0, 0, bus(3, 1)), "p3_reqF0");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 1, p3, 13'h0020, 0, 0, bus(3, 1)), "p3_grant5");
        apply(mk(0, 0, z6, z13, 1, 0, z6, z13, 0, z6, z13, 1, 0, bus(3, 2)), "p3_ack5");
        apply(mk(0, 1, p3, 13'h00F0, 0, 0, z6, z13, 0, z6, z13, 0, 0, bus(3, 2)), "p3_reqF0b");
        apply(mk(0, 0, z6, z13, 0, 1, p3, 13'h0020, 1, p3, 13'h0040, 0, 0, bus(3, 2)), "p3_grant6_rel5");
        apply(mk(0, 0, z6, z13, 1, 0, z6, z13, 0, z6, z13, 1, 0, bus(3, 2)), "p3_ack6");
        apply(mk(0, 1, p3, 13'h00F0, 0, 0, z6, z13, 0, z6, z13, 0, 0, bus(3, 2)), "p3_reqF0c");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 1, p3, 13'h0080, 0, 0, bus(3, 2)), "p3_grant7");
        apply(mk(0, 0, z6, z13, 1, 0, z6, z13, 0, z6, z13, 1, 0, bus(3, 3)), "p3_ack7");
        apply(mk(0, 1, p3, 13'h0020, 0, 0, z6, z13, 0, z6, z13, 0, 0, bus(3, 3)), "p3_req5");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 1, p3, 13'h0020, 0, 0, bus(3, 3)), "p3_regrant5");
        apply(mk(1, 0, z6, z13, 0, 0, z6, z13, 0, z6, z13, 1, 0, 24'd0), "rst3");

        // reset while in GRANT discards the grant and zeroes the pointer
        apply(mk(0, 1, p5, all, 0, 0, z6, z13, 0, z6, z13, 0, 0, 24'd0), "p5_req");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 1, p5, 13'h0001, 0, 0, 24'd0), "p5_grant0");
        apply(mk(1, 0, z6, z13, 0, 0, z6, z13, 0, z6, z13, 1, 0, 24'd0), "rst_in_grant");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 0, z6, z13, 1, 0, 24'd0), "post_rst_busies");
        apply(mk(0, 1, p5, all, 0, 0, z6, z13, 0, z6, z13, 0, 0, 24'd0), "p5_req2");
        apply(mk(0, 0, z6, z13, 0, 0, z6, z13, 1, p5, 13'h0001, 0, 0, 24'd0), "p5_grant0_again");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
